// File: rtl/regfile_wb_sched_if.sv
// Bundle between the write-back scheduler and its neighbours: E/M write
// requests in, regfile write ports and hazard status out.
interface regfile_wb_sched_if #(
  parameter int CNT_W = 8
);
  logic             flush;
  logic             e_valid;
  logic             e_ready;
  logic [3:0]       e_dst;
  logic [31:0]      e_val;
  logic             m_valid;
  logic             m_ready;
  logic [3:0]       m_dst;
  logic [31:0]      m_val;
  logic [3:0]       dstE;
  logic [31:0]      valE;
  logic [3:0]       dstM;
  logic [31:0]      valM;
  logic [7:0]       busy;
  logic             err_illegal;
  logic [CNT_W-1:0] conflict_cnt;

  // Handshake: a request transfers at a posedge where x_valid && x_ready.
  // x_ready is registered state (FIFO not full) and never depends on x_valid.
  modport master (
    output flush, e_valid, e_dst, e_val, m_valid, m_dst, m_val,
    input  e_ready, m_ready, dstE, valE, dstM, valM, busy, err_illegal, conflict_cnt
  );

  modport slave (
    input  flush, e_valid, e_dst, e_val, m_valid, m_dst, m_val,
    output e_ready, m_ready, dstE, valE, dstM, valM, busy, err_illegal, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: per-requester FIFOs (index 0 = E, 1 = M) feeding the
// regfile's two write ports, with same-register serialisation and a busy map.
module regfile_wb_sched #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input logic              clock,
  input logic              reset,
  regfile_wb_sched_if.slave bus
);
  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] NONE = 4'hF;

  typedef struct packed {
    logic [3:0]  dst;
    logic [31:0] val;
  } wr_t;

  wr_t              mem_q [2][DEPTH];
  logic [AW:0]      wp_q [2];
  logic [AW:0]      wp_d [2];
  logic [AW:0]      rp_q [2];
  logic [AW:0]      rp_d [2];
  logic [AW:0]      occ [2];
  logic [AW:0]      slot;
  logic             full [2];
  logic             has [2];
  logic             vld [2];
  logic             acc [2];
  logic             push [2];
  logic             pop [2];
  logic             ill [2];
  wr_t              head [2];
  wr_t              req [2];
  logic             conflict;
  logic [3:0]       dste_q, dste_d, dstm_q, dstm_d;
  logic [31:0]      vale_q, vale_d, valm_q, valm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       busy;

  assign req[0] = '{dst: bus.e_dst, val: bus.e_val};
  assign req[1] = '{dst: bus.m_dst, val: bus.m_val};
  assign vld[0] = bus.e_valid;
  assign vld[1] = bus.m_valid;

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      occ[r]  = wp_q[r] - rp_q[r];
      full[r] = (occ[r] == (AW+1)'(DEPTH));
      has[r]  = (occ[r] != '0);
      head[r] = mem_q[r][rp_q[r][AW-1:0]];
      acc[r]  = vld[r] && !full[r] && !bus.flush;
      // 8-14 are rejected; 4'hF is queued and later issued as a no-op
      push[r] = acc[r] && (!req[r].dst[3] || req[r].dst == NONE);
      ill[r]  = acc[r] && !push[r];
    end
    // Only E drains on a same-register clash, so M's value lands last.
    conflict = has[0] && has[1] && head[0].dst != NONE && head[0].dst == head[1].dst;
    pop[0]   = has[0];
    pop[1]   = has[1] && !conflict;
    err_d    = ill[0] || ill[1];
    dste_d   = pop[0] ? head[0].dst : NONE;
    vale_d   = pop[0] ? head[0].val : vale_q;
    dstm_d   = pop[1] ? head[1].dst : NONE;
    valm_d   = pop[1] ? head[1].val : valm_q;
    cnt_d    = (conflict && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    for (int r = 0; r < 2; r++) begin
      wp_d[r] = wp_q[r] + (AW+1)'(push[r]);
      rp_d[r] = rp_q[r] + (AW+1)'(pop[r]);
    end
    if (bus.flush) begin
      for (int r = 0; r < 2; r++) begin
        wp_d[r] = '0;
        rp_d[r] = '0;
      end
      dste_d = NONE;
      dstm_d = NONE;
      vale_d = vale_q;
      valm_d = valm_q;
      cnt_d  = cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < 2; r++) begin
        wp_q[r] <= '0;
        rp_q[r] <= '0;
      end
      dste_q <= NONE;
      dstm_q <= NONE;
      vale_q <= '0;
      valm_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        wp_q[r] <= wp_d[r];
        rp_q[r] <= rp_d[r];
      end
      dste_q <= dste_d;
      dstm_q <= dstm_d;
      vale_q <= vale_d;
      valm_q <= valm_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clock) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) mem_q[r][wp_q[r][AW-1:0]] <= req[r];
    end
  end

  always_comb begin
    busy = '0;
    slot = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot = rp_q[r] + (AW+1)'(i);
        if ((AW+1)'(i) < occ[r] && !mem_q[r][slot[AW-1:0]].dst[3])
          busy[mem_q[r][slot[AW-1:0]].dst[2:0]] = 1'b1;
      end
    end
    if (!dste_q[3]) busy[dste_q[2:0]] = 1'b1;
    if (!dstm_q[3]) busy[dstm_q[2:0]] = 1'b1;
  end

  assign bus.e_ready      = !full[0];
  assign bus.m_ready      = !full[1];
  assign bus.dstE         = dste_q;
  assign bus.valE         = vale_q;
  assign bus.dstM         = dstm_q;
  assign bus.valM         = valm_q;
  assign bus.busy         = busy;
  assign bus.err_illegal  = err_q;
  assign bus.conflict_cnt = cnt_q;
endmodule
